// File: rtl/argmax_scan.sv
// Streaming argmax over NUM_ITEMS signed scores read from a latency-RD_LAT memory.
// Reports winner, runner-up and their margin; results hold from done until the next start.
module argmax_scan #(
    parameter int NUM_ITEMS = 10,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 14,
    parameter int IDX_W     = 4,
    parameter int RD_LAT    = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  max_idx,
    output logic [DATA_W-1:0] max_val,
    output logic [IDX_W-1:0]  second_idx,
    output logic [DATA_W-1:0] second_val,
    output logic [DATA_W:0]   margin
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ITEMS - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base;
    logic [IDX_W-1:0]  issue_cnt;
    logic [IDX_W-1:0]  recv_cnt;
    logic [RD_LAT-1:0] vld_pipe;
    logic              rd_vld;
    logic              sec_empty;
    logic              accept;

    assign rd_vld = vld_pipe[RD_LAT-1];
    assign accept = (state == IDLE) && start;

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ISSUE;
            end
            ISSUE: begin
                rd_en = 1'b1;
                if (issue_cnt == LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (rd_vld && recv_cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address is forced to zero outside ISSUE so the bus is quiet between scans.
    assign rd_addr = rd_en ? base + ADDR_W'(issue_cnt) : '0;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            base      <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            vld_pipe  <= '0;
        end else begin
            state       <= state_nxt;
            vld_pipe[0] <= rd_en;
            for (int k = 1; k < RD_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
            if (accept) begin
                base      <= base_addr;
                issue_cnt <= '0;
                recv_cnt  <= '0;
            end else begin
                if (rd_en)  issue_cnt <= issue_cnt + 1'b1;
                if (rd_vld) recv_cnt  <= recv_cnt + 1'b1;
            end
        end
    end

    // Item 0 seeds the max; strict compares keep the lowest index on ties.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            max_idx    <= '0;
            max_val    <= '0;
            second_idx <= '0;
            second_val <= '0;
            sec_empty  <= 1'b1;
        end else if (accept) begin
            max_idx    <= '0;
            max_val    <= '0;
            second_idx <= '0;
            second_val <= '0;
            sec_empty  <= 1'b1;
        end else if (rd_vld) begin
            if (recv_cnt == '0) begin
                max_val   <= rd_data;
                max_idx   <= '0;
                sec_empty <= 1'b1;
            end else if ($signed(rd_data) > $signed(max_val)) begin
                second_val <= max_val;
                second_idx <= max_idx;
                sec_empty  <= 1'b0;
                max_val    <= rd_data;
                max_idx    <= recv_cnt;
            end else if (sec_empty || $signed(rd_data) > $signed(second_val)) begin
                second_val <= rd_data;
                second_idx <= recv_cnt;
                sec_empty  <= 1'b0;
            end
        end
    end

    assign margin = {max_val[DATA_W-1], max_val} - {second_val[DATA_W-1], second_val};

endmodule

// File: tb/tb_argmax_scan.sv
// Bench for argmax_scan: two instances (RD_LAT=1 and RD_LAT=3) sharing one memory,
// checked every cycle against a cycle-count/sort model plus hand-computed literals.
module tb_argmax_scan;

    localparam int N = 10;

    logic        Clk;
    logic        Reset;
    logic [31:0] mem [16384];

    logic        start_s   [2];
    logic [13:0] base_s    [2];
    logic [13:0] rd_addr_s [2];
    logic        rd_en_s   [2];
    logic        busy_s    [2];
    logic        done_s    [2];
    logic [3:0]  mi_s      [2];
    logic [3:0]  si_s      [2];
    logic [31:0] mv_s      [2];
    logic [31:0] sv_s      [2];
    logic [32:0] mg_s      [2];

    int n_tests = 0;
    int n_fail  = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Lowest index holding the largest score, optionally skipping one index.
    function automatic int top_idx(input logic [13:0] b, input int skip);
        int best = -1;
        for (int i = 0; i < N; i++)
            if (i != skip && (best < 0 || $signed(mem[14'(b + i)]) > $signed(mem[14'(b + best)])))
                best = i;
        return best;
    endfunction

    function automatic logic [31:0] val_at(input logic [13:0] b, input int i);
        return mem[14'(b + i)];
    endfunction

    for (genvar u = 0; u < 2; u++) begin : g
        localparam int LAT = (u == 0) ? 1 : 3;

        logic [31:0] dp [LAT];
        logic [31:0] rd_data;
        int          c   = 0;
        logic [13:0] bl  = '0;
        int          emi = 0;
        int          esi = 0;
        logic [31:0] emv = '0;
        logic [31:0] esv = '0;
        logic [32:0] emg = '0;

        argmax_scan #(.RD_LAT(LAT)) dut (
            .Clk        (Clk),
            .Reset      (Reset),
            .start      (start_s[u]),
            .base_addr  (base_s[u]),
            .rd_addr    (rd_addr_s[u]),
            .rd_en      (rd_en_s[u]),
            .rd_data    (rd_data),
            .busy       (busy_s[u]),
            .done       (done_s[u]),
            .max_idx    (mi_s[u]),
            .max_val    (mv_s[u]),
            .second_idx (si_s[u]),
            .second_val (sv_s[u]),
            .margin     (mg_s[u])
        );

        always @(posedge Clk) begin
            dp[0] <= mem[rd_addr_s[u]];
            for (int k = 1; k < LAT; k++) dp[k] <= dp[k-1];
        end
        assign rd_data = dp[LAT-1];

        // Model: c is the cycle number within a scan (0 = idle), results latched at done.
        always @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                c <= 0; bl <= '0; emi <= 0; esi <= 0; emv <= '0; esv <= '0; emg <= '0;
            end else if (c == 0) begin
                if (start_s[u]) begin
                    c  <= 1;
                    bl <= base_s[u];
                end
            end else if (c == N + LAT + 1) begin
                c <= 0;
            end else begin
                c <= c + 1;
                if (c + 1 == N + LAT + 1) begin
                    emi <= top_idx(bl, -1);
                    esi <= top_idx(bl, top_idx(bl, -1));
                    emv <= val_at(bl, top_idx(bl, -1));
                    esv <= val_at(bl, top_idx(bl, top_idx(bl, -1)));
                    emg <= 33'(longint'($signed(val_at(bl, top_idx(bl, -1))))
                             - longint'($signed(val_at(bl, top_idx(bl, top_idx(bl, -1))))));
                end
            end
        end

        always @(negedge Clk) begin
            if (Reset) begin
                chk($sformatf("u%0d_rst_busy", u), 64'(busy_s[u]), 64'd0);
                chk($sformatf("u%0d_rst_done", u), 64'(done_s[u]), 64'd0);
                chk($sformatf("u%0d_rst_rd_en", u), 64'(rd_en_s[u]), 64'd0);
                chk($sformatf("u%0d_rst_rd_addr", u), 64'(rd_addr_s[u]), 64'd0);
                chk($sformatf("u%0d_rst_max_idx", u), 64'(mi_s[u]), 64'd0);
                chk($sformatf("u%0d_rst_max_val", u), 64'(mv_s[u]), 64'd0);
                chk($sformatf("u%0d_rst_second_idx", u), 64'(si_s[u]), 64'd0);
                chk($sformatf("u%0d_rst_second_val", u), 64'(sv_s[u]), 64'd0);
                chk($sformatf("u%0d_rst_margin", u), 64'(mg_s[u]), 64'd0);
            end else begin
                chk($sformatf("u%0d_busy", u), 64'(busy_s[u]), 64'(c != 0));
                chk($sformatf("u%0d_done", u), 64'(done_s[u]), 64'(c == N + LAT + 1));
                chk($sformatf("u%0d_rd_en", u), 64'(rd_en_s[u]), 64'(c >= 1 && c <= N));
                chk($sformatf("u%0d_rd_addr", u), 64'(rd_addr_s[u]),
                    64'((c >= 1 && c <= N) ? 14'(bl + c - 1) : 14'd0));
                if (c == 0 || c == N + LAT + 1) begin
                    chk($sformatf("u%0d_max_idx", u), 64'(mi_s[u]), 64'(emi));
                    chk($sformatf("u%0d_max_val", u), 64'(mv_s[u]), 64'(emv));
                    chk($sformatf("u%0d_second_idx", u), 64'(si_s[u]), 64'(esi));
                    chk($sformatf("u%0d_second_val", u), 64'(sv_s[u]), 64'(esv));
                    chk($sformatf("u%0d_margin", u), 64'(mg_s[u]), 64'(emg));
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic load(input int b, input int v [N]);
        for (int i = 0; i < N; i++) mem[14'(b + i)] = 32'(v[i]);
    endtask

    // Start a scan now; 'pulses' bit k re-asserts start in cycle k. Returns in the done cycle.
    task automatic run_scan(input int u, input logic [13:0] b, input logic [63:0] pulses,
                            output int cyc);
        start_s[u] = 1'b1;
        base_s[u]  = b;
        tick();
        start_s[u] = 1'b0;
        cyc = 1;
        while (!done_s[u] && cyc < 60) begin
            start_s[u] = pulses[cyc];
            base_s[u]  = 14'($urandom);
            tick();
            cyc++;
        end
        start_s[u] = 1'b0;
        if (cyc >= 60) begin
            n_tests++;
            n_fail++;
            $display("FAIL u%0d_timeout: no done within %0d cycles", u, cyc);
        end
    endtask

    initial begin
        int v [N];
        int cyc;

        for (int i = 0; i < 16384; i++) mem[i] = '0;
        Reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            start_s[u] = 1'b0;
            base_s[u]  = '0;
        end
        repeat (3) tick();
        Reset = 1'b0;
        repeat (2) tick();

        // Mixed scores with a tie at the top.
        v = '{3, 9, -2, 7, 9, 0, 1, 5, 4, 8};
        load(0, v);
        run_scan(0, 14'd0, 64'd0, cyc);
        chk("t1_done_cycle", 64'(cyc), 64'd12);
        chk("t1_max_idx", 64'(mi_s[0]), 64'd1);
        chk("t1_max_val", 64'(mv_s[0]), 64'd9);
        chk("t1_second_idx", 64'(si_s[0]), 64'd4);
        chk("t1_second_val", 64'(sv_s[0]), 64'd9);
        chk("t1_margin", 64'(mg_s[0]), 64'd0);
        repeat (3) tick();

        // Start re-pulsed in cycles 3 and 8 must be ignored.
        run_scan(0, 14'd0, (64'd1 << 3) | (64'd1 << 8), cyc);
        chk("t2_done_cycle", 64'(cyc), 64'd12);
        chk("t2_max_idx", 64'(mi_s[0]), 64'd1);
        chk("t2_second_idx", 64'(si_s[0]), 64'd4);

        // Back-to-back: start in the cycle right after done, all-negative scores.
        tick();
        v = '{-50, -3, -7, -90, -4, -8, -60, -11, -5, -20};
        load(20, v);
        run_scan(0, 14'd20, 64'd0, cyc);
        chk("t3_done_cycle", 64'(cyc), 64'd12);
        chk("t3_max_idx", 64'(mi_s[0]), 64'd1);
        chk("t3_max_val", 64'(mv_s[0]), 64'(32'hFFFF_FFFD));
        chk("t3_second_idx", 64'(si_s[0]), 64'd4);
        chk("t3_second_val", 64'(sv_s[0]), 64'(32'hFFFF_FFFC));
        chk("t3_margin", 64'(mg_s[0]), 64'd1);
        repeat (2) tick();

        // Reset in cycle 6 of a scan.
        start_s[0] = 1'b1;
        base_s[0]  = 14'd0;
        tick();
        start_s[0] = 1'b0;
        repeat (5) tick();
        chk("t4_pre_busy", 64'(busy_s[0]), 64'd1);
        chk("t4_pre_max_val", 64'(mv_s[0]), 64'd9);
        Reset = 1'b1;
        #1;
        chk("t4_busy", 64'(busy_s[0]), 64'd0);
        chk("t4_rd_en", 64'(rd_en_s[0]), 64'd0);
        chk("t4_max_val", 64'(mv_s[0]), 64'd0);
        chk("t4_margin", 64'(mg_s[0]), 64'd0);
        repeat (2) tick();
        Reset = 1'b0;
        repeat (15) tick();

        // Address wrap: items 0..2 at the top of memory, 3..9 at 0..6.
        mem[16381] = 32'd100;
        mem[16382] = 32'hFFFF_FFFB;
        mem[16383] = 32'd7;
        run_scan(0, 14'd16381, 64'd0, cyc);
        chk("t5_done_cycle", 64'(cyc), 64'd12);
        chk("t5_max_idx", 64'(mi_s[0]), 64'd0);
        chk("t5_max_val", 64'(mv_s[0]), 64'd100);
        chk("t5_second_idx", 64'(si_s[0]), 64'd4);
        chk("t5_second_val", 64'(sv_s[0]), 64'd9);
        chk("t5_margin", 64'(mg_s[0]), 64'd91);
        repeat (2) tick();

        // RD_LAT=3, extreme values, ties at the minimum keep index 0.
        for (int i = 0; i < 9; i++) mem[100 + i] = 32'h8000_0000;
        mem[109] = 32'h7FFF_FFFF;
        run_scan(1, 14'd100, 64'd0, cyc);
        chk("t6_done_cycle", 64'(cyc), 64'd14);
        chk("t6_max_idx", 64'(mi_s[1]), 64'd9);
        chk("t6_max_val", 64'(mv_s[1]), 64'(32'h7FFF_FFFF));
        chk("t6_second_idx", 64'(si_s[1]), 64'd0);
        chk("t6_second_val", 64'(sv_s[1]), 64'(32'h8000_0000));
        chk("t6_margin", 64'(mg_s[1]), 64'h0_FFFF_FFFF);
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
